// File: rtl/i2c_target_adxl_if.sv
// i2c_target_adxl_if
//   Signal bundle between the ADXL345-emulating I2C target and the rest of the
//   system: the open-drain I2C pins, the register-write notification port and
//   the fabric acceleration-sample load port.
//
//   scl_in, sda_in   raw (asynchronous) bus levels seen by the target
//   sda_oe           1 = target pulls SDA low, 0 = released
//   busy             target is inside an addressed transaction
//   wr_strobe        one-clock pulse per accepted register write
//   wr_addr/wr_data  register index / byte of that write
//   sample_valid     load request for sample_data
//   sample_data      {Z1,Z0,Y1,Y0,X1,X0}
//
//   slave  : the target's view
//   master : the view of whatever drives the bus and the sample port
interface i2c_target_adxl_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic        busy;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        sample_valid;
    logic [47:0] sample_data;

    modport slave (
        input  scl_in, sda_in, sample_valid, sample_data,
        output sda_oe, busy, wr_strobe, wr_addr, wr_data
    );

    modport master (
        output scl_in, sda_in, sample_valid, sample_data,
        input  sda_oe, busy, wr_strobe, wr_addr, wr_data
    );
endinterface

// File: rtl/i2c_target_adxl.sv
// i2c_target_adxl
//   I2C target emulating the ADXL345 register interface. SCL/SDA are
//   oversampled with clk, START/STOP are decoded in every state, the address is
//   matched and ACKed, and a 64-byte register file is served with pointer
//   auto-increment. Registers 0x32..0x37 hold acceleration data loaded from
//   fabric; a load arriving during a transaction is deferred until it ends so a
//   burst read always sees one coherent sample.
//
//   clk      system clock (SCL must be at most clk/8)
//   reset_n  synchronous, active-low reset
//   bus      i2c_target_adxl_if.slave (pins, write notification, sample load)
module i2c_target_adxl #(
    parameter logic [6:0] DEV_ADDR  = 7'h53,
    parameter logic [7:0] DEVID_VAL = 8'hE5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    i2c_target_adxl_if.slave      bus
);

    typedef enum logic [2:0] {IDLE, ADDR, ACK, RX, TX, MACK, IGNORE} state_t;

    state_t      state;
    state_t      state_next;

    logic        scl_p0, scl_p1, scl_p2;
    logic        sda_p0, sda_p1, sda_p2;
    logic        scl_rise, scl_fall, start_det, stop_det;

    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic        addr_match;
    logic [6:0]  tx_sr;
    logic [3:0]  bit_cnt;
    logic [7:0]  ptr;
    logic [7:0]  rd_byte;
    logic        rw;
    logic        first_byte;
    logic        mack_ok;
    logic        sda_drive;
    logic        busy_flag;
    logic        busy_clr;
    logic        wr_pulse;
    logic [5:0]  wr_index;
    logic [7:0]  wr_byte;
    logic [7:0]  regs [64];
    logic        pend;
    logic [47:0] pend_data;
    logic        load_en;
    logic [47:0] load_data;

    // A register accepts I2C writes unless it is DEVID, a fabric-loaded
    // sample register, or outside the 64-entry file.
    function automatic logic is_writable(input logic [7:0] p);
        return (p < 8'h40) && (p != 8'h00) && !((p >= 8'h32) && (p <= 8'h37));
    endfunction

    // Synchronizer stage: two flops per pin plus one history flop; idle bus
    // level (high) on reset so no false edge is seen when leaving reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= bus.scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= bus.sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;

    assign rx_byte    = {rx_sr, sda_p1};
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
    assign rd_byte    = (ptr >= 8'h40) ? 8'h00 :
                        (ptr == 8'h00) ? DEVID_VAL : regs[ptr[5:0]];
    assign busy_clr   = (start_det | stop_det) & busy_flag;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else begin
            case (state)
                ADDR: if (scl_rise && bit_cnt == 4'd7)
                          state_next = addr_match ? ACK : IGNORE;
                ACK:  if (scl_fall && sda_drive)
                          state_next = rw ? TX : RX;
                RX:   if (scl_rise && bit_cnt == 4'd7)
                          state_next = ACK;
                TX:   if (scl_fall && bit_cnt == 4'd8)
                          state_next = MACK;
                MACK: if (scl_rise && sda_p1)
                          state_next = IGNORE;
                      else if (scl_fall && mack_ok)
                          state_next = TX;
                default: ;
            endcase
        end
    end

    // Sample load: a deferred sample lands when the transaction ends; a fresh
    // request in that same cycle supersedes it (latest sample wins).
    always_comb begin
        load_en   = 1'b0;
        load_data = sample_data_or_pend();
        if (busy_clr && pend) load_en = 1'b1;
        if (bus.sample_valid && (!busy_flag || busy_clr)) load_en = 1'b1;
    end

    function automatic logic [47:0] sample_data_or_pend();
        if (bus.sample_valid) return bus.sample_data;
        return pend_data;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sda_drive  <= 1'b0;
            busy_flag  <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_index   <= 6'd0;
            wr_byte    <= 8'd0;
            rx_sr      <= 7'd0;
            tx_sr      <= 7'd0;
            bit_cnt    <= 4'd0;
            ptr        <= 8'h00;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            mack_ok    <= 1'b0;
            pend       <= 1'b0;
            pend_data  <= 48'd0;
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
        end else begin
            wr_pulse <= 1'b0;

            if (bus.sample_valid && busy_flag && !busy_clr) begin
                pend      <= 1'b1;
                pend_data <= bus.sample_data;
            end else if (busy_clr) begin
                pend <= 1'b0;
            end
            if (load_en) begin
                regs[6'h32] <= load_data[7:0];
                regs[6'h33] <= load_data[15:8];
                regs[6'h34] <= load_data[23:16];
                regs[6'h35] <= load_data[31:24];
                regs[6'h36] <= load_data[39:32];
                regs[6'h37] <= load_data[47:40];
            end

            if (start_det || stop_det) begin
                sda_drive <= 1'b0;
                busy_flag <= 1'b0;
                bit_cnt   <= 4'd0;
                mack_ok   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (addr_match) begin
                                busy_flag  <= 1'b1;
                                rw         <= sda_p1;
                                first_byte <= 1'b1;
                            end
                        end
                    end
                    // First fall pulls SDA low, second fall ends the ACK slot;
                    // for a read that same fall presents the first data bit.
                    ACK: if (scl_fall) begin
                        bit_cnt <= 4'd0;
                        if (!sda_drive) begin
                            sda_drive <= 1'b1;
                        end else if (rw) begin
                            tx_sr     <= rd_byte[6:0];
                            sda_drive <= ~rd_byte[7];
                        end else begin
                            sda_drive <= 1'b0;
                        end
                    end
                    RX: if (scl_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (first_byte) begin
                                ptr        <= rx_byte;
                                first_byte <= 1'b0;
                            end else begin
                                if (is_writable(ptr)) begin
                                    regs[ptr[5:0]] <= rx_byte;
                                    wr_pulse       <= 1'b1;
                                    wr_index       <= ptr[5:0];
                                    wr_byte        <= rx_byte;
                                end
                                ptr <= ptr + 8'd1;
                            end
                        end
                    end
                    TX: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_drive <= 1'b0;
                                bit_cnt   <= 4'd0;
                                mack_ok   <= 1'b0;
                            end else begin
                                sda_drive <= ~tx_sr[6];
                                tx_sr     <= {tx_sr[5:0], 1'b0};
                            end
                        end
                    end
                    // The pointer advances past every byte sent, including the
                    // one the master NACKs.
                    MACK: begin
                        if (scl_rise) begin
                            ptr     <= ptr + 8'd1;
                            mack_ok <= ~sda_p1;
                        end else if (scl_fall && mack_ok) begin
                            mack_ok   <= 1'b0;
                            tx_sr     <= rd_byte[6:0];
                            sda_drive <= ~rd_byte[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_drive;
    assign bus.busy      = busy_flag;
    assign bus.wr_strobe = wr_pulse;
    assign bus.wr_addr   = wr_index;
    assign bus.wr_data   = wr_byte;

endmodule

// File: doc/i2c_target_adxl.md
Name: i2c_target_adxl

Overview:
- I2C target (responder) for the other end of the FPGA-side I2C master's bus; emulates the ADXL345 accelerometer register interface at 7-bit address 0x53 (write byte 0xA6, read byte 0xA7).
- Used for on-board loopback and simulation of the master before connecting the real sensor.
- Oversamples SCL/SDA with the system clock, decodes START/STOP, matches the address, ACKs, and serves a 64-byte register file with pointer auto-increment.
- Acceleration bytes (DATAX0..DATAZ1) are loaded from fabric.

Parameters:
- DEV_ADDR, 7'h53, 7-bit target address.
- DEVID_VAL, 8'hE5, read-only value at register 0x00.

Ports:
- clk  input  1  system clock (CLOCK_50 domain); SCL must be at most clk/8.
- reset_n  input  1  synchronous, active-low reset.
- scl_in  input  1  raw SCL pin level, asynchronous.
- sda_in  input  1  raw SDA pin level, asynchronous.
- sda_oe  output  1  1 = drive SDA low (open drain); 0 = release.
- busy  output  1  1 from a matched address ACK until STOP or repeated START.
- wr_strobe  output  1  one-clk pulse per ACKed I2C write to a writable register.
- wr_addr  output  6  register index of that write.
- wr_data  output  8  data of that write.
- sample_valid  input  1  load request for sample_data.
- sample_data  input  48  {Z1,Z0,Y1,Y0,X1,X0}; X0 (bits 7:0) goes to register 0x32, Z1 to 0x37.

Behaviour:
- Reset (reset_n=0 at a clk edge): sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, state=IDLE, pointer=0x00, all registers 0x00, pending sample cleared. Reset mid-transfer releases SDA on the next clk.
- Sync: scl_in/sda_in pass 2-flop synchronizers plus one history flop. Edges are detected on synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in every state, including mid-byte, and take priority over bit handling in the same cycle.
- Bit timing: SDA is sampled on SCL rising edges. The target changes SDA only on SCL falling edges; sda_oe updates within 4 clk of the raw SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
  - On the 8th SCL rise: if bits[7:1]==DEV_ADDR, go to ACK and latch the rw bit; otherwise go to IGNORE (no drive) until the next START/STOP.
  - ACK: assert sda_oe on the next SCL fall and release on the following fall. Then:
    - rw=0: go to RX.
    - rw=1: go to TX, which loads the byte at the pointer.
  - RX: shift 8 bits, then ACK. The first byte after the address sets the pointer; later bytes write reg[pointer] and the pointer increments.
  - TX: on each SCL fall, sda_oe = ~current bit (MSB first). After 8 bits, release and go to MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): pointer++, then TX the next byte.
    - 1 (NACK): go to IGNORE until STOP/START.
- STOP goes to IDLE. A repeated START goes to ADDR. In both cases sda_oe is released within 4 clk.
- Pointer: 8 bits; increment wraps 0xFF->0x00.
  - Reads of pointer >=0x40 return 0x00; writes there are ignored.
- Register map:
  - 0x00 returns DEVID_VAL; writes ignored.
  - 0x32-0x37 are fabric-loaded; I2C writes are ignored and produce no wr_strobe.
  - All other indices below 0x40 are read/write.
- Write timing: a write commits on the 8th SCL rise of a data byte. wr_strobe pulses in the same clk, with wr_addr = pointer[5:0] and wr_data = the byte.
- sample_valid:
  - busy=0: registers 0x32-0x37 update on the next clk.
  - busy=1: the data is held pending and applied when busy falls. The latest sample wins, so a multibyte read always returns a coherent set.
- busy goes high at the address ACK and falls on STOP, repeated START, or reset. It stays 0 in IGNORE and for a mismatched address.
- The target does not stretch SCL and does not support general call or 10-bit addressing.

Test Plan:
- START, 0xA6, 0x31, 0x0B, STOP -> ACK after each byte; wr_strobe once with wr_addr=0x31, wr_data=0x0B; reading 0x31 later returns 0x0B.
- START, 0xA6, 0x00, repeated START, 0xA7, master NACK -> data byte 0xE5; sda_oe released after the byte; busy falls at STOP.
- sample_valid with 0x0605_0403_0201, then a 6-byte read from 0x32 with master ACK on the first 5 and NACK on the 6th -> bytes 01 02 03 04 05 06; pointer ends at 0x38.
- START, 0xA8 (address 0x54) -> SDA stays released (NACK); busy=0; later bytes ignored until STOP.
- During a 6-byte read, sample_valid pulses after byte 2 -> all 6 bytes come from the old set; after STOP a re-read returns the new set.
- Pull reset_n low while the target drives an ACK -> sda_oe=0 on the next clk; state=IDLE; the next valid transaction ACKs normally.
